rm_ctrl_fsm: RTL and testbench
==============================

Name: rm_ctrl_fsm

Overview:
Multi-cycle control FSM for the simple RISC machine datapath. It latches one 16-bit instruction per start handshake, decodes it, and sequences the 8x16 register file (readnum/writenum/write) and the datapath load strobes (A, B, C, status) over several cycles. It sits between the instruction source and the register-file/shifter/ALU datapath. It is the only agent that drives register-file write.

Parameters:
DATA_W, 16, width of the sign-extended immediate output sximm8; must be >= 8.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous assert, active-low
s  in  1  start request; sampled only in WAIT
instr  in  16  instruction; captured into the internal IR when s is accepted
w  out  1  idle/ready; 1 only in WAIT
readnum  out  3  register-file read index
writenum  out  3  register-file write index
write  out  1  register-file write enable
loada  out  1  load A register
loadb  out  1  load B register
loadc  out  1  load C register
loads  out  1  load status flags
asel  out  1  1 = force ALU A operand to zero
vsel  out  1  write-back source: 0 = C, 1 = sximm8
shift  out  2  shifter control
alu_op  out  2  ALU operation
sximm8  out  DATA_W  IR[7:0], sign-extended
err  out  1  one-cycle pulse on an undefined instruction

Behaviour:
- IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Legal instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
  - Every other opcode/op combination is undefined.
- States: WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM, all Moore.
- Outputs are decoded from state and IR only. Any strobe not listed for a state is 0.
- WAIT: w=1. When s=1 at a clock edge, IR<=instr and go to DECODE. Otherwise stay; IR holds.
- DECODE (no strobes) branches on the IR:
  - MOV imm -> WR_IMM
  - ADD, AND, CMP -> GET_A
  - MOV reg, MVN -> GET_B
  - undefined -> WAIT with err=1 for this one cycle.
- GET_A: readnum=Rn, loada=1. Next state GET_B.
- GET_B: readnum=Rm, loadb=1, shift=sh. Next state ALU.
- ALU: shift=sh. Next state WR_REG, except CMP returns to WAIT.
  - alu_op: op for opcode 101; 00 for MOV reg.
  - asel=1 for MOV reg only.
  - loadc=1 for all instructions except CMP.
  - loads=1 for CMP only.
- WR_REG: writenum=Rd, vsel=0, write=1. Next state WAIT.
- WR_IMM: writenum=Rn, vsel=1, write=1. Next state WAIT.
- readnum/writenum are 0 in states that do not name them. shift and alu_op are 00 outside the states that set them.
- sximm8 = {(DATA_W-8){IR[7]}, IR[7:0]}, valid in all states.
- Latency, counted in edges from the accept edge until w=1:
  - MOV imm: 2
  - MOV reg, MVN, CMP: 4
  - ADD, AND: 5
  - undefined: 1
- write is asserted in exactly one cycle per legal non-CMP instruction, and never for CMP or undefined instructions.
- s while not in WAIT is ignored; there is no queueing. If s is held high, a new instruction is accepted on the edge where the FSM is in WAIT.
- Reset, including mid-instruction: state=WAIT and IR=0 immediately. All strobes, err, readnum and writenum go to 0 and w=1. An aborted instruction never writes.

Decomposition:
- Shared package rm_pkg holds:
  - state enum
  - opcode/op localparams (OPC_MOV=3'b110, OPC_ALU=3'b101, ALU_ADD/CMP/AND/MVN)
  - vsel encodings (VSEL_C=0, VSEL_IMM=1)
- One sub-module, rm_instr_decode: combinational IR field extraction, legality check and sximm8 sign extension.

Test Plan:
- Reset then instr=0xD007 (MOV R0,#7) with s=1 -> WR_IMM cycle has write=1, writenum=0, vsel=1, sximm8=0x0007; w=1 two edges after accept.
- instr=0xD1FE (MOV R1,#-2) -> sximm8=0xFFFE, writenum=1, exactly one write cycle.
- instr=0xA148 (ADD R2,R1,R0,LSL#1) -> in order:
  - GET_A: readnum=1, loada=1
  - GET_B: readnum=0, loadb=1, shift=01
  - ALU: loadc=1, alu_op=00
  - WR_REG: writenum=2, write=1
  - w=1 after 5 edges.
- instr=0xA900 (CMP R1,R0) -> ALU cycle has loads=1, loadc=0, alu_op=01; write never asserted; w=1 after 4 edges.
- instr=0xE000 (undefined) -> err=1 for exactly one cycle, no strobes, w=1 after 1 edge. s pulsed during a busy ADD is ignored.
- rst_n driven low during the GET_B cycle of 0xA148 -> immediately w=1, all strobes 0; no write to R2 follows after rst_n releases.

Source files
------------

// File: rtl/rm_pkg.sv
// Shared definitions for the simple RISC machine controller:
// FSM state encoding, instruction opcode/op fields and write-back select codes.
package rm_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    // Instruction class (IR[15:13])
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field (IR[12:11]) under OPC_MOV
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;

    // op field (IR[12:11]) under OPC_ALU; doubles as the ALU operation code
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // Register-file write-back source
    localparam logic VSEL_C   = 1'b0;
    localparam logic VSEL_IMM = 1'b1;

endpackage

// File: rtl/rm_instr_decode.sv
// Combinational instruction decoder: splits the latched IR into its fields,
// classifies it, flags undefined encodings and sign-extends the 8-bit immediate.
module rm_instr_decode
    import rm_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [15:0]       ir,
    output logic [1:0]        op,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [1:0]        sh,
    output logic [2:0]        rm,
    output logic              is_mov_imm,
    output logic              is_mov_reg,
    output logic              is_alu,
    output logic              legal,
    output logic [DATA_W-1:0] sximm8
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    // Every op under the ALU opcode is defined; only two ops under MOV are.
    assign is_mov_imm = (opcode == OPC_MOV) && (op == MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign legal      = is_mov_imm | is_mov_reg | is_alu;

    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: rtl/rm_ctrl_fsm.sv
// Multi-cycle controller for the RISC machine datapath. Latches one instruction
// per start handshake and sequences register-file reads/writes and the
// A/B/C/status load strobes. Outputs are Moore: decoded from state and IR only.
module rm_ctrl_fsm
    import rm_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s,
    input  logic [15:0]       instr,
    output logic              w,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              vsel,
    output logic [1:0]        shift,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] sximm8,
    output logic              err
);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] ir_reg;

    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic        is_mov_imm;
    logic        is_mov_reg;
    logic        is_alu;
    logic        legal;

    rm_instr_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .ir         (ir_reg),
        .op         (op),
        .rn         (rn),
        .rd         (rd),
        .sh         (sh),
        .rm         (rm),
        .is_mov_imm (is_mov_imm),
        .is_mov_reg (is_mov_reg),
        .is_alu     (is_alu),
        .legal      (legal),
        .sximm8     (sximm8)
    );

    // State register; reset drops straight back to WAIT so an aborted
    // instruction can never reach a write state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_WAIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction register: loaded only on an accepted start in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg <= 16'h0000;
        end else if ((state_reg == S_WAIT) && s) begin
            ir_reg <= instr;
        end
    end

    // Next-state and Moore output decode; every strobe defaults to inactive.
    always_comb begin
        state_next = state_reg;
        w          = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        vsel       = VSEL_C;
        shift      = 2'b00;
        alu_op     = 2'b00;
        err        = 1'b0;

        case (state_reg)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    err        = 1'b1;
                    state_next = S_WAIT;
                end else if (is_mov_imm) begin
                    state_next = S_WR_IMM;
                end else if (is_mov_reg || (is_alu && (op == ALU_MVN))) begin
                    // Single-operand instructions skip the A fetch.
                    state_next = S_GET_B;
                end else begin
                    state_next = S_GET_A;
                end
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                shift      = sh;
                state_next = S_ALU;
            end
            S_ALU: begin
                shift  = sh;
                alu_op = is_alu ? op : ALU_ADD;
                // MOV reg computes 0 + shifted Rm, so A is forced to zero.
                asel   = is_mov_reg;
                if (is_alu && (op == ALU_CMP)) begin
                    loads      = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    loadc      = 1'b1;
                    state_next = S_WR_REG;
                end
            end
            S_WR_REG: begin
                writenum   = rd;
                vsel       = VSEL_C;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            S_WR_IMM: begin
                writenum   = rn;
                vsel       = VSEL_IMM;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_rm_ctrl_fsm.sv
// Scoreboard bench for rm_ctrl_fsm: stimulus pushes the expected strobe cycles
// and latency per instruction; a negedge monitor compares every cycle in which
// the DUT drives a strobe, and every return to idle.
module tb_rm_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        vsel;
    logic [1:0]  shift;
    logic [1:0]  alu_op;
    logic [15:0] sximm8;
    logic        err;

    rm_ctrl_fsm #(.DATA_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .vsel     (vsel),
        .shift    (shift),
        .alu_op   (alu_op),
        .sximm8   (sximm8),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        write;
        logic        err;
        logic        asel;
        logic        vsel;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  shift;
        logic [1:0]  alu_op;
        logic [15:0] sximm8;
    } rec_t;

    rec_t exp_q[$];
    int   lat_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    int   busy_cnt = 0;

    function automatic rec_t rec_a(input logic [2:0] rn, input logic [15:0] sx);
        rec_t r = '0;
        r.loada = 1'b1; r.readnum = rn; r.sximm8 = sx;
        return r;
    endfunction

    function automatic rec_t rec_b(input logic [2:0] rm, input logic [1:0] sh,
                                   input logic [15:0] sx);
        rec_t r = '0;
        r.loadb = 1'b1; r.readnum = rm; r.shift = sh; r.sximm8 = sx;
        return r;
    endfunction

    function automatic rec_t rec_alu(input logic [1:0] aop, input logic as,
                                     input logic ld_s, input logic [1:0] sh,
                                     input logic [15:0] sx);
        rec_t r = '0;
        r.alu_op = aop; r.asel = as; r.loads = ld_s; r.loadc = ~ld_s;
        r.shift = sh; r.sximm8 = sx;
        return r;
    endfunction

    function automatic rec_t rec_wr(input logic [2:0] wn, input logic vs,
                                    input logic [15:0] sx);
        rec_t r = '0;
        r.write = 1'b1; r.writenum = wn; r.vsel = vs; r.sximm8 = sx;
        return r;
    endfunction

    function automatic rec_t rec_err(input logic [15:0] sx);
        rec_t r = '0;
        r.err = 1'b1; r.sximm8 = sx;
        return r;
    endfunction

    // Monitor: compares each strobe cycle and each busy-period length.
    always @(negedge clk) begin
        rec_t obs;
        if (!rst_n) begin
            busy_cnt = 0;
        end else if (mon_en) begin
            obs = '{w:w, loada:loada, loadb:loadb, loadc:loadc, loads:loads,
                    write:write, err:err, asel:asel, vsel:vsel,
                    readnum:readnum, writenum:writenum, shift:shift,
                    alu_op:alu_op, sximm8:sximm8};
            if (loada | loadb | loadc | loads | write | err) begin
                rec_t ex;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe t=%0t got=%h required=none", $time, obs);
                end else begin
                    ex = exp_q.pop_front();
                    if (obs !== ex) begin
                        n_fail++;
                        $display("FAIL strobe_cycle t=%0t got=%h required=%h", $time, obs, ex);
                    end else begin
                        $display("strobe ok t=%0t rec=%h", $time, obs);
                    end
                end
            end
            if (!w) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                n_checks++;
                if (lat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_busy got=%0d required=none", busy_cnt);
                end else begin
                    int exl;
                    exl = lat_q.pop_front();
                    if (busy_cnt != exl) begin
                        n_fail++;
                        $display("FAIL latency got=%0d required=%0d", busy_cnt, exl);
                    end else begin
                        $display("latency ok %0d edges", busy_cnt);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end else begin
            $display("check ok %s = %h", name, got);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (w === 1'b1) break;
        end
        if (w !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout got=w=%b required=1", w);
        end
        @(posedge clk); #1;
    endtask

    // Issue one instruction (caller is in WAIT, just after an edge).
    task automatic run_instr(input logic [15:0] ins);
        s = 1'b1; instr = ins;
        @(posedge clk); #1;
        s = 1'b0; instr = 16'h0000;
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0; s = 1'b0; instr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_w", {31'd0, w}, 32'd1);
        check("reset_strobes", {26'd0, write, loada, loadb, loadc, loads, err}, 32'd0);
        check("reset_idx", {26'd0, readnum, writenum}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // MOV R0,#7
        exp_q.push_back(rec_wr(3'd0, 1'b1, 16'h0007)); lat_q.push_back(2);
        run_instr(16'hD007);
        // MOV R1,#-2
        exp_q.push_back(rec_wr(3'd1, 1'b1, 16'hFFFE)); lat_q.push_back(2);
        run_instr(16'hD1FE);
        // ADD R2,R1,R0,LSL#1
        exp_q.push_back(rec_a(3'd1, 16'h0048));
        exp_q.push_back(rec_b(3'd0, 2'b01, 16'h0048));
        exp_q.push_back(rec_alu(2'b00, 1'b0, 1'b0, 2'b01, 16'h0048));
        exp_q.push_back(rec_wr(3'd2, 1'b0, 16'h0048)); lat_q.push_back(5);
        run_instr(16'hA148);
        // CMP R1,R0
        exp_q.push_back(rec_a(3'd1, 16'h0000));
        exp_q.push_back(rec_b(3'd0, 2'b00, 16'h0000));
        exp_q.push_back(rec_alu(2'b01, 1'b0, 1'b1, 2'b00, 16'h0000)); lat_q.push_back(4);
        run_instr(16'hA900);
        // undefined opcode 111
        exp_q.push_back(rec_err(16'h0000)); lat_q.push_back(1);
        run_instr(16'hE000);
        // undefined 110/11
        exp_q.push_back(rec_err(16'h0000)); lat_q.push_back(1);
        run_instr(16'hD800);
        // MOV R5,R3,LSR#1 (sh=10)
        exp_q.push_back(rec_b(3'd3, 2'b10, 16'hFFB3));
        exp_q.push_back(rec_alu(2'b00, 1'b1, 1'b0, 2'b10, 16'hFFB3));
        exp_q.push_back(rec_wr(3'd5, 1'b0, 16'hFFB3)); lat_q.push_back(4);
        run_instr(16'hC0B3);
        // MVN R7,R2
        exp_q.push_back(rec_b(3'd2, 2'b00, 16'hFFE2));
        exp_q.push_back(rec_alu(2'b11, 1'b0, 1'b0, 2'b00, 16'hFFE2));
        exp_q.push_back(rec_wr(3'd7, 1'b0, 16'hFFE2)); lat_q.push_back(4);
        run_instr(16'hB8E2);
        // AND R3,R2,R4
        exp_q.push_back(rec_a(3'd2, 16'h0064));
        exp_q.push_back(rec_b(3'd4, 2'b00, 16'h0064));
        exp_q.push_back(rec_alu(2'b10, 1'b0, 1'b0, 2'b00, 16'h0064));
        exp_q.push_back(rec_wr(3'd3, 1'b0, 16'h0064)); lat_q.push_back(5);
        run_instr(16'hB264);

        // ADD with a stray start pulse while busy: must be ignored
        exp_q.push_back(rec_a(3'd1, 16'h0048));
        exp_q.push_back(rec_b(3'd0, 2'b01, 16'h0048));
        exp_q.push_back(rec_alu(2'b00, 1'b0, 1'b0, 2'b01, 16'h0048));
        exp_q.push_back(rec_wr(3'd2, 1'b0, 16'h0048)); lat_q.push_back(5);
        s = 1'b1; instr = 16'hA148;
        @(posedge clk); #1;               // DECODE
        s = 1'b0; instr = 16'h0000;
        @(posedge clk); #1;               // GET_A
        s = 1'b1; instr = 16'hD007;
        @(posedge clk); #1;               // GET_B
        s = 1'b0; instr = 16'h0000;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        // ADD aborted by reset during GET_B
        exp_q.push_back(rec_a(3'd1, 16'h0048));
        exp_q.push_back(rec_b(3'd0, 2'b01, 16'h0048));
        s = 1'b1; instr = 16'hA148;
        @(posedge clk); #1;               // DECODE
        s = 1'b0; instr = 16'h0000;
        @(posedge clk);                   // GET_A
        @(posedge clk);                   // GET_B
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_w", {31'd0, w}, 32'd1);
        check("abort_strobes", {26'd0, write, loada, loadb, loadc, loads, err}, 32'd0);
        check("abort_idx", {26'd0, readnum, writenum}, 32'd0);
        check("abort_sximm8", {16'd0, sximm8}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_abort_idle_w", {31'd0, w}, 32'd1);

        check("exp_q_drained", exp_q.size(), 32'd0);
        check("lat_q_drained", lat_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
